// File: rtl/sd_frame_scheduler_pkg.sv
// Shared types and widths for the SD frame scheduler and its tick generator.
package sd_sched_pkg;

  localparam int BLOCK_ADDR_W = 32;
  localparam int FRAME_IDX_W  = 16;
  localparam int MAX_RETRIES  = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_DONE,
    FINISHED,
    FAULT
  } sched_state_t;

endpackage

// File: rtl/sd_frame_scheduler_tick.sv
// Frame-period divider: one-cycle tick every PERIOD enabled cycles, held at zero while disabled.
module frame_tick_gen #(
  parameter int PERIOD = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] count_reg;
  logic             at_end;

  assign at_end = (count_reg == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count_reg <= '0;
    end else if (at_end) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tick = enable && at_end;

endmodule

// File: rtl/sd_frame_scheduler.sv
// Streams FRAME_COUNT frames of BLOCKS_PER_FRAME single-block reads at a fixed frame rate.
// Define SD_SCHED_RETRY_EN to re-issue a failed block up to MAX_RETRIES times before faulting.
module sd_frame_scheduler
  import sd_sched_pkg::*;
#(
  parameter int          SYS_CLK_FREQ     = 100_000_000,
  parameter int          FRAME_RATE       = 30,
  parameter int          BLOCKS_PER_FRAME = 12,
  parameter logic [31:0] FIRST_BLOCK      = 32'd0,
  parameter int          FRAME_COUNT      = 6572
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        card_ready,
  input  logic        start,
  output logic        read_req,
  output logic [31:0] read_addr,
  input  logic        read_ack,
  input  logic        read_done,
  input  logic        read_error,
  output logic        frame_tick,
  output logic [15:0] frame_index,
  output logic        busy,
  output logic        underrun,
  output logic        done,
  output logic        fault
);

  localparam int TICK_PERIOD = (SYS_CLK_FREQ / FRAME_RATE > 0) ? SYS_CLK_FREQ / FRAME_RATE : 1;
  localparam int BLK_W       = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;

  sched_state_t            state_reg, state_next;
  logic [BLOCK_ADDR_W-1:0] addr_reg, addr_next;
  logic [FRAME_IDX_W-1:0]  frame_reg, frame_next;
  logic [BLK_W-1:0]        block_reg, block_next;
  logic                    pending_reg, pending_next;
  logic                    tick, active, good_done, last_block, last_frame, frame_end;
`ifdef SD_SCHED_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  logic [RETRY_W-1:0]      retry_reg, retry_next;
`endif

  assign active     = (state_reg == WAIT_TICK) || (state_reg == ISSUE) || (state_reg == WAIT_DONE);
  assign good_done  = read_done && !read_error;
  assign last_block = (block_reg == BLK_W'(BLOCKS_PER_FRAME - 1));
  assign last_frame = (frame_reg == FRAME_IDX_W'(FRAME_COUNT - 1));
  assign frame_end  = (state_reg == WAIT_DONE) && good_done && last_block;

  frame_tick_gen #(.PERIOD(TICK_PERIOD)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (active),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      frame_reg   <= '0;
      block_reg   <= '0;
      pending_reg <= 1'b0;
`ifdef SD_SCHED_RETRY_EN
      retry_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      frame_reg   <= frame_next;
      block_reg   <= block_next;
      pending_reg <= pending_next;
`ifdef SD_SCHED_RETRY_EN
      retry_reg   <= retry_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    frame_next   = frame_reg;
    block_next   = block_reg;
    pending_next = pending_reg;
`ifdef SD_SCHED_RETRY_EN
    retry_next   = retry_reg;
`endif
    case (state_reg)
      IDLE, FINISHED: begin
        if (start && card_ready) begin
          state_next   = WAIT_TICK;
          addr_next    = FIRST_BLOCK;
          frame_next   = '0;
          block_next   = '0;
          pending_next = 1'b0;
`ifdef SD_SCHED_RETRY_EN
          retry_next   = '0;
`endif
        end
      end
      WAIT_TICK: begin
        // A tick owed from an overrunning frame and a fresh tick together leave one still owed.
        pending_next = pending_reg && tick;
        if (tick || pending_reg) begin
          state_next = ISSUE;
          block_next = '0;
        end
      end
      ISSUE: begin
        if (tick) pending_next = 1'b1;
        if (read_ack) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tick) pending_next = 1'b1;
        if (good_done) begin
          addr_next = addr_reg + 32'd1;
`ifdef SD_SCHED_RETRY_EN
          retry_next = '0;
`endif
          if (last_block) begin
            block_next = '0;
            if (last_frame) begin
              state_next   = FINISHED;
              pending_next = 1'b0;
            end else begin
              frame_next = frame_reg + 16'd1;
              state_next = WAIT_TICK;
            end
          end else begin
            block_next = block_reg + BLK_W'(1);
            state_next = ISSUE;
          end
        end else if (read_done) begin
`ifdef SD_SCHED_RETRY_EN
          if (retry_reg == RETRY_W'(MAX_RETRIES)) begin
            state_next = FAULT;
          end else begin
            retry_next = retry_reg + RETRY_W'(1);
            state_next = ISSUE;
          end
`else
          state_next = FAULT;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    read_req    = (state_reg == ISSUE);
    read_addr   = addr_reg;
    frame_index = frame_reg;
    busy        = active;
    frame_tick  = tick;
    underrun    = tick && ((state_reg == ISSUE) || ((state_reg == WAIT_DONE) && !frame_end));
    done        = (state_reg == FINISHED);
    fault       = (state_reg == FAULT);
  end

endmodule

// File: tb/tb_sd_frame_scheduler.sv
// Randomised scoreboard bench for sd_frame_scheduler, plus a small address-wrap instance.
module tb_sd_frame_scheduler;

  localparam int          CLK_HZ = 1000;
  localparam int          RATE   = 10;
  localparam int          BPF    = 2;
  localparam int          FCOUNT = 3;
  localparam logic [31:0] FIRST  = 32'd100;
  localparam int          PERIOD = CLK_HZ / RATE;
  localparam logic [31:0] W_FIRST = 32'hFFFF_FFFF;
`ifdef SD_SCHED_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int EV_REQ = 0, EV_DONE = 1, EV_FAULT = 2;

  logic clk = 1'b0;
  logic reset, card_ready, start, read_ack, read_done, read_error;
  logic read_req, frame_tick, busy, underrun, done, fault;
  logic [31:0] read_addr;
  logic [15:0] frame_index;
  logic w_start, w_ack, w_done;
  logic w_req, w_tick, w_busy, w_ur, w_fin, w_fault;
  logic [31:0] w_addr;
  logic [15:0] w_fidx;

  always #5 clk = ~clk;

  sd_frame_scheduler #(.SYS_CLK_FREQ(CLK_HZ), .FRAME_RATE(RATE), .BLOCKS_PER_FRAME(BPF),
                       .FIRST_BLOCK(FIRST), .FRAME_COUNT(FCOUNT)) dut (
    .clk(clk), .reset(reset), .card_ready(card_ready), .start(start),
    .read_req(read_req), .read_addr(read_addr), .read_ack(read_ack),
    .read_done(read_done), .read_error(read_error), .frame_tick(frame_tick),
    .frame_index(frame_index), .busy(busy), .underrun(underrun), .done(done), .fault(fault));

  sd_frame_scheduler #(.SYS_CLK_FREQ(1000), .FRAME_RATE(100), .BLOCKS_PER_FRAME(2),
                       .FIRST_BLOCK(W_FIRST), .FRAME_COUNT(1)) dut_wrap (
    .clk(clk), .reset(reset), .card_ready(card_ready), .start(w_start),
    .read_req(w_req), .read_addr(w_addr), .read_ack(w_ack),
    .read_done(w_done), .read_error(1'b0), .frame_tick(w_tick),
    .frame_index(w_fidx), .busy(w_busy), .underrun(w_ur), .done(w_fin), .fault(w_fault));

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [15:0] frame;
    int          at;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  final_done_now = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void expect_event(input int kind);
    ev_t ev;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: actual kind=%0d required none (cycle %0d)", kind, cyc);
      return;
    end
    ev = sb.pop_front();
    if (ev.kind != kind) begin
      errors++;
      $display("FAIL event_kind: actual=%0d required=%0d (cycle %0d)", kind, ev.kind, cyc);
    end else if (kind == EV_REQ) begin
      check("read_addr", read_addr, ev.addr);
      check("frame_index", frame_index, ev.frame);
    end else begin
      check("event_cycle", cyc, ev.at);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected address follows directly from frame/block position.
  function automatic void push_req(input int frame, input int block);
    ev_t ev;
    ev.kind  = EV_REQ;
    ev.addr  = FIRST + 32'(frame * BPF + block);
    ev.frame = 16'(frame);
    ev.at    = 0;
    sb.push_back(ev);
  endfunction

  function automatic void push_end(input int kind);
    ev_t ev;
    ev.kind  = kind;
    ev.addr  = '0;
    ev.frame = '0;
    ev.at    = cyc + 1;
    sb.push_back(ev);
  endfunction

  // Monitor: frame-tick cadence, underrun prediction, tick-to-request latency, scoreboard pops.
  initial begin
    bit prev_req, prev_done, prev_fault, in_progress, owed, req_rise, exp_tick, exp_ur;
    int busy_cycles, expect_req_at;
    prev_req = 0; prev_done = 0; prev_fault = 0; in_progress = 0; owed = 0;
    busy_cycles = 0; expect_req_at = -1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 0; prev_done = 0; prev_fault = 0; in_progress = 0; owed = 0;
        busy_cycles = 0; expect_req_at = -1;
      end else begin
        req_rise    = read_req && !prev_req;
        busy_cycles = busy ? busy_cycles + 1 : 0;
        exp_tick    = busy && (busy_cycles % PERIOD == 0);
        if (req_rise) in_progress = 1'b1;
        if (frame_tick || exp_tick) check("frame_tick", frame_tick, exp_tick);
        if (expect_req_at == cyc) begin
          check("tick_to_req", req_rise, 1'b1);
          expect_req_at = -1;
        end
        if (busy && !in_progress && (exp_tick || owed)) begin
          expect_req_at = cyc + 1;
          owed = owed && exp_tick;
        end
        exp_ur = exp_tick && in_progress && !final_done_now;
        if (underrun || exp_ur) check("underrun", underrun, exp_ur);
        if (exp_ur || (exp_tick && final_done_now)) owed = 1'b1;
        if (final_done_now) in_progress = 1'b0;
        if (!busy) begin
          owed = 1'b0;
          in_progress = 1'b0;
        end
        if (req_rise) expect_event(EV_REQ);
        if (done && !prev_done) expect_event(EV_DONE);
        if (fault && !prev_fault) expect_event(EV_FAULT);
        prev_req = read_req; prev_done = done; prev_fault = fault;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("reset_outputs", {read_req, busy, frame_tick, underrun, done, fault, frame_index, read_addr}, '0);
    reset = 1'b0;
    sb.delete();
    step();
  endtask

  // SD master model with random ack delay and read latency; error injection on err_addr.
  task automatic play(input int lmin, input int lmax, input int err_pct,
                      input logic [31:0] err_addr, input int n_err);
    int frame, block, attempt, waited, bad_left;
    bit run, err;
    logic [31:0] model_addr;
    frame = 0; block = 0; attempt = 0; bad_left = n_err; run = 1'b1;
    card_ready = 1'b1;
    start = 1'b1;
    push_req(0, 0);
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    while (run) begin
      waited = 0;
      while (!read_req && waited < 4 * PERIOD) begin
        step();
        waited++;
      end
      if (!read_req) begin
        check("req_timeout", read_req, 1'b1);
        break;
      end
      repeat ($urandom_range(0, 2)) step();
      read_ack = 1'b1;
      step();
      read_ack = 1'b0;
      repeat ($urandom_range(lmin, lmax) - 1) step();
      model_addr = FIRST + 32'(frame * BPF + block);
      err = ($urandom_range(0, 99) < err_pct);
      if (model_addr == err_addr && bad_left > 0) begin
        err = 1'b1;
        bad_left--;
      end
      read_done  = 1'b1;
      read_error = err;
      if (!err) begin
        attempt = 0;
        if (block == BPF - 1) begin
          final_done_now = 1'b1;
          if (frame == FCOUNT - 1) begin
            push_end(EV_DONE);
            run = 1'b0;
          end else begin
            frame++;
            block = 0;
            push_req(frame, block);
          end
        end else begin
          block++;
          push_req(frame, block);
        end
      end else if (RETRY && attempt < 3) begin
        attempt++;
        push_req(frame, block);
      end else begin
        push_end(EV_FAULT);
        run = 1'b0;
      end
      step();
      read_done = 1'b0; read_error = 1'b0; final_done_now = 1'b0;
    end
    repeat (4) step();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic wrap_test();
    int waited;
    logic [31:0] exp_addr;
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      waited = 0;
      while (!w_req && waited < 100) begin
        step();
        waited++;
      end
      exp_addr = W_FIRST + 32'(b);
      check("wrap_req", w_req, 1'b1);
      check("wrap_addr", w_addr, exp_addr);
      w_ack = 1'b1; step(); w_ack = 1'b0; step();
      w_done = 1'b1; step(); w_done = 1'b0;
    end
    step();
    check("wrap_finished", w_fin, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_req;
    reset = 1'b1; card_ready = 1'b0; start = 1'b0;
    read_ack = 1'b0; read_done = 1'b0; read_error = 1'b0;
    w_start = 1'b0; w_ack = 1'b0; w_done = 1'b0;
    repeat (2) step();
    do_reset();

    // start without card_ready must be ignored
    start = 1'b1; step(); start = 1'b0;
    seen_req = 1'b0;
    repeat (PERIOD + 5) begin
      step();
      seen_req |= read_req | busy;
    end
    check("no_card_activity", seen_req, 1'b0);

    play(5, 5, 0, 32'd0, 0);
    play(120, 120, 0, 32'd0, 0);
    play(60, 130, 0, 32'd0, 0);
    repeat (3) play(1, 70, 0, 32'd0, 0);

    play(3, 8, 0, FIRST + 32'd1, 1);
    do_reset();
    play(3, 8, 0, FIRST + 32'd1, 4);
    check("fault_sticky", fault, 1'b1);
    do_reset();

    // reset while a request is outstanding
    card_ready = 1'b1; start = 1'b1; push_req(0, 0); step(); start = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !read_req; i++) step();
    check("mid_reset_req_seen", read_req, 1'b1);
    do_reset();
    play(2, 10, 0, 32'd0, 0);

    play(2, 20, 15, 32'd0, 0);
    do_reset();

    wrap_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
